// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the fetch PC, issues reads to a 1-cycle
// instruction memory and buffers returned instructions in a 2-entry FIFO for decode.
module fetch_stage #(
    parameter int unsigned      DBITS    = 32,
    parameter int unsigned      INSTBITS = 32,
    parameter int unsigned      INSTSIZE = 4,
    parameter logic [DBITS-1:0] START_PC = 32'h100
) (
    input  logic                clk,
    input  logic                reset,
    output logic [DBITS-1:0]    fe_pc,
    input  logic                bp_flush,
    input  logic [DBITS-1:0]    bp_next_pc,
    output logic                imem_req,
    output logic [DBITS-1:0]    imem_addr,
    input  logic [INSTBITS-1:0] imem_rdata,
    output logic                de_valid,
    input  logic                de_ready,
    output logic [DBITS-1:0]    de_pc,
    output logic [INSTBITS-1:0] de_inst
);

    logic [DBITS-1:0]    pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [DBITS-1:0]    inflight_pc_q, inflight_pc_d;
    logic [DBITS-1:0]    fifo_pc_q [2];
    logic [DBITS-1:0]    fifo_pc_d [2];
    logic [INSTBITS-1:0] fifo_inst_q [2];
    logic [INSTBITS-1:0] fifo_inst_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                deq;
    logic                enq;
    logic                issue;
    logic [2:0]          credit;

    assign de_valid  = (count_q != 2'd0);
    assign deq       = de_valid & de_ready;
    assign de_pc     = fifo_pc_q[rd_ptr_q];
    assign de_inst   = fifo_inst_q[rd_ptr_q];

    // Occupancy after this cycle's dequeue, counting the response still in flight;
    // issuing only while it is <= 1 guarantees a free slot for every response.
    assign credit    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
    assign issue     = !reset && !bp_flush && (credit <= 3'd1);
    assign enq       = inflight_q && !bp_flush;

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign fe_pc     = pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_inst_d   = fifo_inst_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + {1'b0, enq} - {1'b0, deq};

        if (issue) begin
            pc_d          = bp_next_pc;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end

        if (enq) begin
            fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
            fifo_inst_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d              = ~wr_ptr_q;
        end

        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // A redirect squashes the buffer and the response arriving now; a
        // same-cycle dequeue counts as consumed.
        if (bp_flush) begin
            pc_d       = bp_next_pc;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= START_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fifo_pc_q     <= '{default: '0};
            fifo_inst_q   <= '{default: '0};
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_inst_q   <= fifo_inst_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(enq && (count_q == 2'd2) && !deq))
                else $error("fetch_stage: response arrived with FIFO full");
            if (issue) begin
                assert (bp_next_pc == pc_q + DBITS'(INSTSIZE))
                    else $error("fetch_stage: sequential next PC is not fe_pc+INSTSIZE");
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue scoreboard of issued PCs.
module tb_fetch_stage;

    localparam logic [31:0] START = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bp_flush = 1'b0;
    logic        de_ready = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] fe_pc, bp_next_pc, imem_addr, de_pc, de_inst;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, de_valid;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] mdl_pc = START;

    always #5 clk = ~clk;

    // Predictor model: sequential unless redirecting.
    assign bp_next_pc = bp_flush ? tgt : fe_pc + 32'd4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    fetch_stage #(
        .DBITS(32), .INSTBITS(32), .INSTSIZE(4), .START_PC(START)
    ) dut (
        .clk(clk), .reset(reset), .fe_pc(fe_pc),
        .bp_flush(bp_flush), .bp_next_pc(bp_next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .de_valid(de_valid), .de_ready(de_ready),
        .de_pc(de_pc), .de_inst(de_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then score what the DUT shows.
    task automatic cyc(input logic rst, input logic rdy, input logic fl, input logic [31:0] t);
        logic [31:0] e;
        @(negedge clk);
        reset = rst;
        de_ready = rdy;
        bp_flush = fl;
        tgt = t;
        #1;
        if (!rst && de_valid && de_ready) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_de_pc", de_pc, e);
                chk("sb_de_inst", de_inst, mem_word(e));
            end
        end
        if (rst || fl) begin
            sb_q.delete();
            mdl_pc = rst ? START : t;
        end else if (imem_req) begin
            chk("sb_imem_addr", imem_addr, mdl_pc);
            sb_q.push_back(mdl_pc);
            mdl_pc = mdl_pc + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_fe_pc", fe_pc, START);
        chk("rst_de_valid", 32'(de_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_de_pc", de_pc, 32'h0);
        chk("rst_de_inst", de_inst, 32'h0);

        // Streaming from reset
        run(1);
        chk("s0_req", 32'(imem_req), 32'd1);
        chk("s0_fe_pc", fe_pc, START);
        chk("s0_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("s1_req", 32'(imem_req), 32'd1);
        chk("s1_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("s2_valid", 32'(de_valid), 32'd1);
        chk("s2_de_pc", de_pc, 32'h100);

        // Stall for five cycles
        stall(1);
        chk("st3_req", 32'(imem_req), 32'd0);
        chk("st3_de_pc", de_pc, 32'h104);
        stall(2);
        chk("st5_fe_pc", fe_pc, 32'h10C);
        chk("st5_req", 32'(imem_req), 32'd0);
        stall(2);
        chk("st7_valid", 32'(de_valid), 32'd1);
        chk("st7_fe_pc", fe_pc, 32'h10C);
        chk("st7_de_pc", de_pc, 32'h104);
        run(1);
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_de_pc", de_pc, 32'h104);
        run(1);
        chk("rel1_de_pc", de_pc, 32'h108);
        run(1);
        chk("rel2_de_pc", de_pc, 32'h10C);
        run(3);

        // Flush in a running stream
        cyc(1'b0, 1'b1, 1'b1, 32'h200);
        chk("fl_req", 32'(imem_req), 32'd0);
        run(1);
        chk("fl1_valid", 32'(de_valid), 32'd0);
        chk("fl1_req", 32'(imem_req), 32'd1);
        chk("fl1_addr", imem_addr, 32'h200);
        run(1);
        chk("fl2_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("fl3_valid", 32'(de_valid), 32'd1);
        chk("fl3_de_pc", de_pc, 32'h200);
        run(1);
        chk("fl4_de_pc", de_pc, 32'h204);
        run(2);

        // Flush while full and stalled
        stall(3);
        cyc(1'b0, 1'b0, 1'b1, 32'h300);
        chk("ff_valid", 32'(de_valid), 32'd1);
        chk("ff_req", 32'(imem_req), 32'd0);
        run(1);
        chk("ff1_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("ff2_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("ff3_de_pc", de_pc, 32'h300);
        run(1);
        chk("ff4_de_pc", de_pc, 32'h304);
        run(2);

        // Flush concurrent with dequeue and an arriving response
        cyc(1'b0, 1'b1, 1'b1, 32'h400);
        chk("fd_valid", 32'(de_valid), 32'd1);
        chk("fd_req", 32'(imem_req), 32'd0);
        run(1);
        chk("fd1_valid", 32'(de_valid), 32'd0);
        chk("fd1_addr", imem_addr, 32'h400);
        run(1);
        chk("fd2_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("fd3_de_pc", de_pc, 32'h400);
        run(1);
        chk("fd4_de_pc", de_pc, 32'h404);
        run(1);

        // Reset mid-stream with the FIFO full
        stall(3);
        chk("rm_full", 32'(de_valid), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rm_req", 32'(imem_req), 32'd0);
        run(1);
        chk("rm1_valid", 32'(de_valid), 32'd0);
        chk("rm1_fe_pc", fe_pc, START);
        chk("rm1_req", 32'(imem_req), 32'd1);
        run(1);
        chk("rm2_valid", 32'(de_valid), 32'd0);
        run(1);
        chk("rm3_de_pc", de_pc, 32'h100);
        run(1);
        chk("rm4_de_pc", de_pc, 32'h104);
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage. It holds the fetch PC, presents it to the branch predictor every cycle, and loads the predictor's next-PC when a request is issued or a redirect arrives. It issues requests to a synchronous instruction memory with 1-cycle read latency. Returned instructions are buffered in a 2-entry FIFO and handed to decode over a valid/ready handshake. On a predictor flush, all in-flight and buffered work is squashed and fetch restarts at the redirect target.

Parameters:
DBITS, 32, PC/address width
INSTBITS, 32, instruction width
INSTSIZE, 4, bytes per instruction (PC increment is computed by the predictor, not here)
START_PC, 32'h100, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
fe_pc  out  DBITS  current fetch PC to branch predictor (= pc_q)
bp_flush  in  1  predictor redirect (mispredict detected downstream)
bp_next_pc  in  DBITS  predictor next PC: target when bp_flush=1, else fe_pc+INSTSIZE
imem_req  out  1  read request this cycle
imem_addr  out  DBITS  read address (= pc_q)
imem_rdata  in  INSTBITS  read data, valid the cycle after imem_req
de_valid  out  1  FIFO head valid to decode
de_ready  in  1  decode accepts head this cycle
de_pc  out  DBITS  PC of head entry
de_inst  out  INSTBITS  instruction of head entry

Behaviour:
- State: pc_q; inflight_q (request issued last cycle); inflight_pc_q; FIFO of 2 entries {pc, inst} with rd_ptr, wr_ptr (1 bit each, wrap 1->0) and count 0..2.
- Reset (sync, dominates everything): pc_q=START_PC, inflight_q=0, count=0, pointers=0, entries=0. Outputs: de_valid=0, de_pc=0, de_inst=0, imem_req=0, fe_pc=START_PC.
- deq = de_valid & de_ready. de_valid = (count!=0). de_pc/de_inst come from the head entry, driven combinationally.
- Issue rule (credit): imem_req = !reset & !bp_flush & ((count + inflight_q - deq) <= 1). This rule guarantees FIFO space for every response. It sustains 1 instruction/cycle while de_ready=1.
- On issue: pc_q <= bp_next_pc; inflight_q <= 1; inflight_pc_q <= pc_q. With no issue and no flush: pc_q holds, inflight_q <= 0.
- Response: if inflight_q=1 and no flush this cycle, write {inflight_pc_q, imem_rdata} at wr_ptr and advance wr_ptr.
- Count update: count += enq - deq. Simultaneous enq and deq are legal at count 1 or 2.
- An enq when count=2 with no deq is illegal. The credit rule prevents it; this condition carries an assertion.
- Latency: a request issued in cycle N returns data in N+1, which is captured at the end of N+1. de_valid is first seen in N+2.
- Flush in cycle N (bp_flush=1):
  - pc_q <= bp_next_pc; imem_req=0 in N.
  - FIFO is cleared (count=0, ptrs=0). inflight_q <= 0, and the response arriving in N (from an N-1 request) is discarded.
  - A same-cycle deq is treated as consumed; decode is flushed by the predictor anyway.
  - Target is requested in N+1; de_valid=1 with de_pc=target in N+3.
  - Flush has priority over enq, deq and issue. Back-to-back flushes each reload pc_q; the last one wins.
- Reset asserted mid-operation: behaves as a flush to START_PC and also forces pc_q=START_PC regardless of bp_flush.
- Stall (de_ready=0): the FIFO fills to 2 and issue stops. fe_pc and imem_addr hold the next unfetched PC. No instruction is lost or duplicated.
- PC wrap at 2^DBITS is whatever bp_next_pc supplies; no checking is done here.

Test Plan:
- Reset, bp_next_pc=fe_pc+4, de_ready=1 -> imem_req in cycles 0,1,2…; de_valid from cycle 2 with de_pc 0x100,0x104,0x108…, one per cycle.
- Stall: de_ready=0 from cycle 3 for 5 cycles -> count reaches 2, imem_req=0, fe_pc constant. On release, the de_pc sequence continues with no gap or duplicate.
- Flush: bp_flush=1, bp_next_pc=0x200 in cycle 6 of the stream -> de_valid=0 in cycles 7–8; cycle 9 de_pc=0x200, then 0x204.
- Flush during full stall: count=2, inflight=0, flush to 0x300 -> FIFO empty next cycle; first de_pc=0x300 three cycles after flush. Old entries never appear.
- Flush concurrent with deq and response (count=1, inflight=1) -> neither the head nor the response is ever presented again; only the 0x400 stream follows.
- Reset mid-stream at count=2 -> next cycle de_valid=0, fe_pc=0x100; restart matches the first scenario.
